// File: rtl/qspi_rb_packer.sv
// qspi_rb_packer: packs a flash readback byte stream into 32-bit
// buffer-memory words and reports a per-packet completion status.
module qspi_rb_packer #(
  parameter int MEM_ADDR_BITS = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cfg_valid,
  input  logic [31:0]              cfg_data,
  output logic                     cfg_ready,
  input  logic [7:0]               flash_in_data,
  input  logic                     flash_in_valid,
  input  logic                     flash_in_tlast,
  output logic                     flash_in_ready,
  output logic [MEM_ADDR_BITS-1:2] mem_addr,
  output logic                     mem_valid,
  output logic                     mem_wr,
  output logic [31:0]              mem_out_data,
  input  logic                     mem_ready,
  output logic                     stat_valid,
  output logic [31:0]              stat_data,
  input  logic                     stat_ready
);

  localparam int AW = MEM_ADDR_BITS - 2;

  typedef enum logic [1:0] {
    IDLE,
    PACK,
    WRITE,
    STAT
  } state_t;

  state_t state_q, state_d;

  logic [1:0]    rst_sync;
  logic          rst_n;
  logic [AW-1:0] addr_q;
  logic [31:0]   word_q;
  logic [15:0]   cnt_q;
  logic [1:0]    lane_q;
  logic          wrap_q;
  logic          last_q;

  logic cfg_hs;
  logic byte_hs;
  logic mem_hs;
  logic byte_done;
  logic unused_cfg;

  // Assert asynchronously, release two edges later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  assign unused_cfg = ^{cfg_data[31:MEM_ADDR_BITS], cfg_data[1:0]};

  assign cfg_hs    = cfg_valid & cfg_ready;
  assign byte_hs   = flash_in_valid & flash_in_ready;
  assign mem_hs    = mem_valid & mem_ready;
  assign byte_done = (lane_q == 2'd3) | flash_in_tlast;

  always_comb begin
    state_d        = state_q;
    cfg_ready      = 1'b0;
    flash_in_ready = 1'b0;
    mem_valid      = 1'b0;
    stat_valid     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) state_d = PACK;
      end
      PACK: begin
        flash_in_ready = 1'b1;
        if (flash_in_valid && byte_done) state_d = WRITE;
      end
      WRITE: begin
        mem_valid = 1'b1;
        if (mem_ready) state_d = last_q ? STAT : PACK;
      end
      STAT: begin
        stat_valid = 1'b1;
        if (stat_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_wr       = mem_valid;
  assign mem_addr     = addr_q;
  assign mem_out_data = word_q;
  assign stat_data    = {wrap_q, 15'b0, cnt_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      word_q <= '0;
      cnt_q  <= '0;
      lane_q <= '0;
      wrap_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      if (cfg_hs) begin
        addr_q <= cfg_data[MEM_ADDR_BITS-1:2];
        word_q <= '0;
        cnt_q  <= '0;
        lane_q <= '0;
        wrap_q <= 1'b0;
        last_q <= 1'b0;
      end
      if (byte_hs) begin
        word_q[{lane_q, 3'b000} +: 8] <= flash_in_data;
        lane_q <= lane_q + 2'd1;
        last_q <= flash_in_tlast;
        if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
      end
      if (mem_hs) begin
        word_q <= '0;
        addr_q <= addr_q + 1'b1;
        if (&addr_q) wrap_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/qspi_rb_packer.md
QSPI_RB_PACKER -- requirements
Module: qspi_rb_packer

Interface
REQ-001 SHALL have parameter MEM_ADDR_BITS, default 16, the byte-address width of the buffer memory.
REQ-002 SHALL have ports: clk  in  1  sole clock; every flop is on its rising edge.
REQ-003 SHALL have ports: reset_n  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports: cfg_valid in 1, cfg_data in 32, cfg_ready out 1  arm command; cfg_data[MEM_ADDR_BITS-1:2] is the start word address.
REQ-005 SHALL have ports: flash_in_data in 8, flash_in_valid in 1, flash_in_tlast in 1, flash_in_ready out 1  flash readback byte stream (AXIS).
REQ-006 SHALL have ports: mem_addr out [MEM_ADDR_BITS-1:2], mem_valid out 1, mem_wr out 1, mem_out_data out 32, mem_ready in 1  buffer memory write port.
REQ-007 SHALL have ports: stat_valid out 1, stat_data out 32, stat_ready in 1  per-packet completion status.

Function
REQ-008 SHALL implement states IDLE, PACK, WRITE, STAT; all handshakes complete on a clk edge with valid&ready both high.
REQ-009 IDLE: cfg_ready=1, all other readies/valids 0; cfg handshake latches start address, clears byte count, word register and wrap flag, and enters PACK.
REQ-010 PACK: flash_in_ready=1; each accepted byte goes to lane lane_idx=byte_cnt[1:0], lane 0 -> mem_out_data[7:0], lane 3 -> [31:24].
REQ-011 PACK: byte_cnt increments per accepted byte, saturating at 0xFFFF (the lane index keeps advancing modulo 4 past saturation).
REQ-012 PACK -> WRITE on the edge accepting a byte into lane 3 or a byte with tlast=1; a last flag records tlast.
REQ-013 WRITE: mem_valid=1, mem_wr=1, flash_in_ready=0; mem_addr and mem_out_data hold steady until mem_ready.
REQ-014 On WRITE handshake: word register cleared, word address incremented modulo 2^(MEM_ADDR_BITS-2); the wrap flag is set when the address rolls from all-ones to 0.
REQ-015 On WRITE handshake: next state is STAT if last flag set, else PACK.
REQ-016 Partial final word: unwritten lanes SHALL be 0; the write is still a full 32-bit word.
REQ-017 Timing: mem_valid SHALL assert the cycle after the completing byte is accepted.
REQ-018 Throughput: at most 4 bytes per 5 clk with mem_ready tied high.
REQ-019 STAT: stat_valid=1, stat_data={wrap_flag, 15'b0, byte_cnt[15:0]}, held until stat_ready; then IDLE.
REQ-020 flash_in_ready SHALL be 0 outside PACK (backpressure, no byte dropped); cfg_ready SHALL be 0 outside IDLE.
REQ-021 mem_wr SHALL equal mem_valid (write-only port); mem_valid and stat_valid never high together.
REQ-022 flash_in_data/tlast SHALL be ignored when flash_in_valid=0; no combinational path from any input valid to the same channel's ready.

Reset
REQ-023 reset_n low SHALL immediately force IDLE; mem_valid, mem_wr, stat_valid, flash_in_ready = 0; mem_addr, mem_out_data, stat_data, byte_cnt, wrap flag = 0; cfg_ready = 1.
REQ-024 Reset mid-packet SHALL discard the partial word with no memory write and no status; after release the block waits for a new cfg.
REQ-025 Release of reset_n is synchronised internally so the first active edge after deassertion is clean.

Verification
REQ-026 Arm addr 0x0100, send bytes 11 22 33 44 55 66 77 88 (tlast on 88), mem_ready=1 -> writes 0x44332211 @word 0x40, 0x88776655 @0x41; stat_data=0x00000008.
REQ-027 Arm 0x0000, send AA BB (tlast on BB) -> single write 0x0000BBAA @word 0; stat 0x00000002.
REQ-028 Arm 0xFFFC (MEM_ADDR_BITS=16), 8 bytes -> writes @0x3FFF then @0x0000; stat_data=0x80000008.
REQ-029 Hold mem_ready=0 for 10 cycles during WRITE with valid bytes pending -> flash_in_ready=0 throughout, mem_addr/data stable, no byte lost; resumes on mem_ready.
REQ-030 Pulse reset_n low after 3 bytes of a packet -> no mem_valid, no stat_valid; re-arm and 4-byte packet completes normally with stat 0x00000004.
REQ-031 Hold stat_ready=0 for 5 cycles -> stat_valid/stat_data stable, cfg_ready=0, flash_in_ready=0 until accept.
